// File: rtl/led16_pkg.sv
// led16_pkg: shared state type, grant bit indices and LED pattern constants for led16_sched
package led16_pkg;
    typedef enum logic [1:0] {IDLE, SHOW, STAT, ALERT} state_t;
    localparam int GNT_SHOW  = 0;
    localparam int GNT_STAT  = 1;
    localparam int GNT_ALERT = 2;
    localparam logic [15:0] PAT_ON  = 16'hFFFF;
    localparam logic [15:0] PAT_OFF = 16'h0000;
endpackage

// File: rtl/led16_satcnt.sv
// led16_satcnt: clear/increment counter that saturates at MAX
// ports: clk, rst (sync, active-high), clr (priority over inc), inc, cnt (current count)
module led16_satcnt #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : (inc && cnt_q != W'(MAX)) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
    assign cnt = cnt_q;
endmodule

// File: rtl/led16_sched.sv
// led16_sched: priority scheduler sharing one 16-LED bank between show, static pattern and alert blink
// ports: clk, rst (sync, active-high); show_req, stat_req, alert_req (level requests);
//        stat_data (pattern latched on STAT entry); drv_led (from external led16_drv);
//        drv_en, drv_mod (to led16_drv); gnt (one-hot {alert, stat, show}); led (bank value)
module led16_sched import led16_pkg::*; #(
    parameter int HOLD_CYC = 1024,
    parameter int MODE_W   = 26,
    parameter int BLINK_W  = 23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        show_req,
    input  logic        stat_req,
    input  logic [15:0] stat_data,
    input  logic        alert_req,
    input  logic [15:0] drv_led,
    output logic        drv_en,
    output logic        drv_mod,
    output logic [2:0]  gnt,
    output logic [15:0] led
);
    localparam int HW = $clog2(HOLD_CYC + 1);
    state_t              state_q, state_d, top_req;
    logic [HW-1:0]       hold_cnt;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic [BLINK_W-1:0]  blink_q, blink_d;
    logic [15:0]         pat_q, pat_d;
    logic [2:0]          gnt_q, gnt_d;
    logic                drv_en_q, drv_en_d, drv_mod_q, drv_mod_d;
    logic                own_req, stay;

    led16_satcnt #(.W(HW), .MAX(HOLD_CYC)) u_hold (
        .clk (clk),
        .rst (rst),
        .clr (!stay),
        .inc (1'b1),
        .cnt (hold_cnt)
    );

    always_comb begin
        top_req   = alert_req ? ALERT : stat_req ? STAT : show_req ? SHOW : IDLE;
        own_req   = state_q == SHOW ? show_req : state_q == STAT ? stat_req :
                    state_q == ALERT ? alert_req : 1'b0;
        // Re-arbitrate from idle, on owner release or on alert; otherwise only a held-out SHOW yields to STAT.
        state_d   = (state_q == IDLE || !own_req || alert_req) ? top_req :
                    (state_q == SHOW && stat_req && hold_cnt == HW'(HOLD_CYC)) ? STAT : state_q;
        stay      = state_d == state_q;
        mode_d    = (stay && state_q == SHOW) ? mode_q + 1'b1 : '0;
        drv_mod_d = (stay && state_q == SHOW) ? drv_mod_q ^ (&mode_q) : 1'b0;
        blink_d   = (stay && state_q == ALERT) ? blink_q + 1'b1 : '0;
        pat_d     = (state_d == STAT && !stay) ? stat_data : pat_q;
        drv_en_d  = state_d == SHOW;
        gnt_d            = '0;
        gnt_d[GNT_SHOW]  = state_d == SHOW;
        gnt_d[GNT_STAT]  = state_d == STAT;
        gnt_d[GNT_ALERT] = state_d == ALERT;
        led = state_q == SHOW  ? drv_led :
              state_q == STAT  ? pat_q :
              state_q == ALERT ? (blink_q[BLINK_W-1] ? PAT_OFF : PAT_ON) : PAT_OFF;
    end

    always_ff @(posedge clk) begin
        state_q   <= rst ? IDLE : state_d;
        mode_q    <= rst ? '0 : mode_d;
        blink_q   <= rst ? '0 : blink_d;
        pat_q     <= rst ? '0 : pat_d;
        gnt_q     <= rst ? '0 : gnt_d;
        drv_en_q  <= rst ? 1'b0 : drv_en_d;
        drv_mod_q <= rst ? 1'b0 : drv_mod_d;
    end

    assign gnt     = gnt_q;
    assign drv_en  = drv_en_q;
    assign drv_mod = drv_mod_q;
endmodule

// File: tb/tb_led16_sched.sv
// tb_led16_sched: directed and randomized checks of led16_sched against a cycles-since-entry model
module tb_led16_sched;
    localparam int HOLD    = 4;
    localparam int MODE_W  = 3;
    localparam int BLINK_W = 2;

    logic        clk = 1'b0, rst = 1'b1;
    logic        show_req = 1'b0, stat_req = 1'b0, alert_req = 1'b0;
    logic [15:0] stat_data = '0, drv_led = '0;
    logic        drv_en, drv_mod;
    logic [2:0]  gnt;
    logic [15:0] led;

    int          tests = 0, fails = 0;
    int          m_st = 0, m_age = 0;
    logic [15:0] m_lat = '0;
    logic [15:0] blink_seq [8] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000,
                                   16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};

    led16_sched #(.HOLD_CYC(HOLD), .MODE_W(MODE_W), .BLINK_W(BLINK_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .show_req  (show_req),
        .stat_req  (stat_req),
        .stat_data (stat_data),
        .alert_req (alert_req),
        .drv_led   (drv_led),
        .drv_en    (drv_en),
        .drv_mod   (drv_mod),
        .gnt       (gnt),
        .led       (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: state 0 idle, 1 show, 2 stat, 3 alert; m_age counts cycles since the state was entered.
    task automatic model_step();
        int top, nst;
        bit own;
        if (rst) begin
            m_st = 0; m_age = 0; m_lat = '0;
        end else begin
            top = alert_req ? 3 : stat_req ? 2 : show_req ? 1 : 0;
            own = (m_st == 1 && show_req) || (m_st == 2 && stat_req) || (m_st == 3 && alert_req);
            if (m_st == 0)                                     nst = top;
            else if (alert_req)                                nst = 3;
            else if (!own)                                     nst = top;
            else if (m_st == 1 && stat_req && m_age >= HOLD)   nst = 2;
            else                                               nst = m_st;
            if (nst == 2 && m_st != 2) m_lat = stat_data;
            m_age = (nst == m_st) ? m_age + 1 : 0;
            m_st  = nst;
        end
    endtask

    task automatic model_cmp();
        logic [15:0] e_led;
        e_led = m_st == 1 ? drv_led : m_st == 2 ? m_lat :
                m_st == 3 ? (((m_age % (1 << BLINK_W)) < (1 << (BLINK_W - 1))) ? 16'hFFFF : 16'h0000) : 16'h0000;
        chk("gnt",     gnt,     m_st == 0 ? 0 : (1 << (m_st - 1)));
        chk("drv_en",  drv_en,  m_st == 1);
        chk("drv_mod", drv_mod, (m_st == 1) && (((m_age >> MODE_W) & 1) == 1));
        chk("led",     led,     e_led);
    endtask

    task automatic step(input logic r, input logic sh, input logic st, input logic al, input logic [15:0] d);
        @(negedge clk);
        rst = r; show_req = sh; stat_req = st; alert_req = al; stat_data = d;
        drv_led = 16'($urandom);
        @(posedge clk);
        model_step();
        #1;
        model_cmp();
    endtask

    initial begin
        logic sh, st, al;
        // reset with every request high
        step(1, 1, 1, 1, 16'h0);
        step(1, 1, 1, 1, 16'h0);
        chk("rst_gnt", gnt, 3'b000);
        chk("rst_led", led, 16'h0000);
        chk("rst_drv_en", drv_en, 1'b0);
        step(0, 1, 1, 1, 16'h0);
        chk("rel_gnt_alert", gnt, 3'b100);
        // show, then stat after the hold time
        step(1, 0, 0, 0, 16'h0);
        step(0, 1, 0, 0, 16'hA5C3);
        chk("show_entry", gnt, 3'b001);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 0, 16'hA5C3);
            chk("show_hold", gnt, 3'b001);
        end
        step(0, 1, 1, 0, 16'hA5C3);
        chk("stat_entry", gnt, 3'b010);
        chk("stat_led", led, 16'hA5C3);
        step(0, 1, 1, 0, 16'h0F0F);
        chk("stat_latched", led, 16'hA5C3);
        // alert preempts stat, blinks, then stat returns with a fresh pattern
        step(0, 1, 1, 1, 16'h0F0F);
        chk("alert_gnt", gnt, 3'b100);
        chk("blink0", led, blink_seq[0]);
        for (int k = 1; k < 8; k++) begin
            step(0, 1, 1, 1, 16'h0F0F);
            chk("blink", led, blink_seq[k]);
        end
        step(0, 1, 1, 0, 16'h1234);
        chk("restat_gnt", gnt, 3'b010);
        chk("restat_led", led, 16'h1234);
        // mode toggle over 20 show cycles
        step(1, 0, 0, 0, 16'h0);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, 0, 16'h0);
            chk("mode_en", drv_en, 1'b1);
            chk("mode_mod", drv_mod, (i >= 8 && i < 16));
            chk("mode_led", led, drv_led);
        end
        // owner release with simultaneous stat request
        step(0, 0, 1, 0, 16'h5A5A);
        chk("simul_gnt", gnt, 3'b010);
        chk("simul_led", led, 16'h5A5A);
        // reset in the middle of alert
        step(0, 0, 0, 1, 16'h0);
        chk("alert2_gnt", gnt, 3'b100);
        step(1, 0, 0, 1, 16'h0);
        chk("midrst_gnt", gnt, 3'b000);
        chk("midrst_led", led, 16'h0000);
        step(0, 0, 0, 1, 16'h0);
        chk("reentry_gnt", gnt, 3'b100);
        // randomized long-lived requests
        sh = 0; st = 0; al = 0;
        for (int i = 0; i < 3000; i++) begin
            sh ^= ($urandom_range(7) == 0);
            st ^= ($urandom_range(9) == 0);
            al ^= ($urandom_range(15) == 0);
            step($urandom_range(199) == 0, sh, st, al, 16'($urandom));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
